// File: rtl/twos_serial_decode_pkg.sv
// Shared types and helpers for the bit-serial two's-complement decoder.
// Default word width is 8.
package twos_serial_decode_pkg;

    localparam int TWOS_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } twos_state_e;

    // Bit-counter width; a 2-bit word still needs one counter bit.
    function automatic int cnt_width(input int w);
        if (w <= 2) begin
            return 1;
        end else begin
            return $clog2(w);
        end
    endfunction

endpackage

// File: rtl/twos_serial_decode_bit.sv
// One serial cell of the copy-until-first-one-then-invert negation.
// For a negative word, bits up to and including the first 1 pass through,
// every later bit is inverted; non-negative words pass through untouched.
module twos_serial_decode_bit (
    input  logic b,
    input  logic sign,
    input  logic seen_one,
    output logic ob,
    output logic seen_one_nxt
);

    // Output bit and updated first-one flag for the current bit position.
    always_comb begin
        ob           = b;
        seen_one_nxt = seen_one | b;
        if (sign && seen_one) begin
            ob = ~b;
        end else begin
            ob = b;
        end
    end

endmodule

// File: rtl/twos_serial_decode.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Accepts a WIDTH-bit signed word, walks it LSB-first one bit per clock and
// presents sign plus unsigned magnitude with valid/ready handshakes.
// Optional macro TWOS_DEC_EARLY_EXIT_EN: non-negative words bypass the
// serial pass and are presented one cycle after acceptance.
module twos_serial_decode
    import twos_serial_decode_pkg::*;
#(
    parameter int WIDTH = TWOS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mag,
    output logic             sign,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = cnt_width(WIDTH);

    twos_state_e        state_r;
    twos_state_e        state_nxt_s;
    logic [WIDTH-1:0]   sr_r;
    logic [WIDTH-1:0]   mag_r;
    logic               sign_r;
    logic               seen_one_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               ob_s;
    logic               seen_one_nxt_s;
    logic               accept_s;
    logic               last_bit_s;

    assign accept_s   = in_valid & in_ready_r;
    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

    twos_serial_decode_bit u_bit (
        .b            (sr_r[0]),
        .sign         (sign_r),
        .seen_one     (seen_one_r),
        .ob           (ob_s),
        .seen_one_nxt (seen_one_nxt_s)
    );

    // Next-state decode for the accept / shift / present sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef TWOS_DEC_EARLY_EXIT_EN
                    if (i[WIDTH-1]) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
`else
                    state_nxt_s = ST_SHIFT;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags and serial datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sr_r        <= {WIDTH{1'b0}};
            mag_r       <= {WIDTH{1'b0}};
            sign_r      <= 1'b0;
            seen_one_r  <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sr_r       <= i;
                        sign_r     <= i[WIDTH-1];
                        seen_one_r <= 1'b0;
                        cnt_r      <= {CNT_W{1'b0}};
`ifdef TWOS_DEC_EARLY_EXIT_EN
                        if (!i[WIDTH-1]) begin
                            mag_r <= i;
                        end
`endif
                    end
                end
                ST_SHIFT: begin
                    sr_r       <= {1'b0, sr_r[WIDTH-1:1]};
                    mag_r      <= {ob_s, mag_r[WIDTH-1:1]};
                    seen_one_r <= seen_one_nxt_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
                end
                ST_DONE: begin
                    // Outputs held until the consumer takes them.
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign mag       = mag_r;
    assign sign      = sign_r;

endmodule
